// File: rtl/sipo_deserializer_pkg.sv
// Shared types for the serial-in/parallel-out receiver.
// The FSM state type lives here so checkers and benches can name the same states.
package sipo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } sipo_state_t;

endpackage : sipo_pkg

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles N-bit words from a qualified bit stream
// and hands them out through a one-entry valid/ready output register.
//
// Output handshake: data_out is valid while out_valid=1 and is held stable until
// a cycle with out_valid && out_ready, which consumes it; a word completing in that
// same cycle replaces it without a bubble.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int N         = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         serial_in,
   input  logic         bit_valid,
   input  logic         start,
   output logic [N-1:0] data_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         frame_err,
   output logic         overflow
);

   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   sipo_state_t   state_q;
   logic [CW-1:0] bit_cnt_q;
   logic [N-1:0]  shift_q;
   logic [N-1:0]  shift_d;
   logic [N-1:0]  data_q;
   logic          out_valid_q;
   logic          frame_err_q;
   logic          overflow_q;

   logic take_start;
   logic take_bit;
   logic word_done;

   assign take_start = bit_valid && start;
   assign take_bit   = bit_valid && !start && (state_q == RECV);
   assign word_done  = take_bit && (bit_cnt_q == LAST);

   // FSM and bit counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (take_start) begin
            frame_err_q <= (state_q == RECV);
            state_q     <= RECV;
            bit_cnt_q   <= CW'(1);
         end else if (take_bit) begin
            if (bit_cnt_q == LAST) begin
               state_q   <= IDLE;
               bit_cnt_q <= '0;
            end else begin
               bit_cnt_q <= bit_cnt_q + CW'(1);
            end
         end
      end
   end

   // A start reloads from a clean register so an aborted word leaves no residue.
   always_comb begin
      shift_d = shift_q;
      if (take_start) begin
         shift_d = LSB_FIRST ? {serial_in, {(N-1){1'b0}}}
                             : {{(N-1){1'b0}}, serial_in};
      end else if (take_bit) begin
         shift_d = LSB_FIRST ? {serial_in, shift_q[N-1:1]}
                             : {shift_q[N-2:0], serial_in};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   // Output register: the completed word is shift_d on the edge sampling its last bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q      <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         overflow_q <= 1'b0;
         if (word_done) begin
            if (!out_valid_q || out_ready) begin
               data_q      <= shift_d;
               out_valid_q <= 1'b1;
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign data_out  = data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == RECV);
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an LSB-first and an MSB-first instance share
// one bit stream; a negedge monitor pops expected words as each output is consumed.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       serial_in;
   logic       bit_valid;
   logic       start;
   logic       out_ready;

   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       busy_a, busy_b;
   logic       ferr_a, ferr_b;
   logic       ovf_a, ovf_b;

   int checks = 0;
   int errors = 0;
   int ferr_cnt_a = 0, ferr_cnt_b = 0;
   int ovf_cnt_a = 0, ovf_cnt_b = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   sipo_deserializer #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid),
      .start(start), .data_out(data_a), .out_valid(valid_a), .out_ready(out_ready),
      .busy(busy_a), .frame_err(ferr_a), .overflow(ovf_a)
   );

   sipo_deserializer #(.N(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid),
      .start(start), .data_out(data_b), .out_valid(valid_b), .out_ready(out_ready),
      .busy(busy_b), .frame_err(ferr_b), .overflow(ovf_b)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- check helpers ----------------
   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (ferr_a) ferr_cnt_a++;
         if (ferr_b) ferr_cnt_b++;
         if (ovf_a)  ovf_cnt_a++;
         if (ovf_b)  ovf_cnt_b++;
         if (valid_a && out_ready) begin
            if (exp_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL word_lsb unexpected actual=%02h expected=none t=%0t", data_a, $time);
            end else begin
               check8("word_lsb", data_a, exp_a.pop_front());
            end
         end
         if (valid_b && out_ready) begin
            if (exp_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL word_msb unexpected actual=%02h expected=none t=%0t", data_b, $time);
            end else begin
               check8("word_msb", data_b, exp_b.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic d, input logic s);
      @(posedge clk); #1;
      bit_valid = 1'b1;
      start     = s;
      serial_in = d;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      bit_valid = 1'b0;
      start     = 1'b0;
      serial_in = 1'b0;
   endtask

   // b[i] is the i-th transmitted bit; the last bit is left driven for the caller.
   task automatic send_bits(input logic [7:0] b, input bit gaps, input bit drop,
                            input bit ready_on_last);
      for (int i = 0; i < 8; i++) begin
         if (gaps && i != 0) idle_cycle();
         drive_bit(b[i], i == 0);
         if (i == 7 && ready_on_last) out_ready = 1'b1;
      end
      if (!drop) begin
         exp_a.push_back(b);
         exp_b.push_back(rev8(b));
      end
   endtask

   task automatic send_word(input logic [7:0] b, input bit gaps, input bit drop);
      send_bits(b, gaps, drop, 1'b0);
      idle_cycle();
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk); #1;
      out_ready = r;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int ovf0, ferr0;
      reset_n   = 1'b0;
      serial_in = 1'b0;
      bit_valid = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check8("rst_data_lsb", data_a, 8'h00);
      check8("rst_data_msb", data_b, 8'h00);
      check1("rst_valid", valid_a, 1'b0);
      check1("rst_busy", busy_a, 1'b0);
      check1("rst_frame_err", ferr_a, 1'b0);
      check1("rst_overflow", ovf_a, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // 1: A5 with continuous bit_valid; word appears on the edge sampling bit 8
      send_bits(8'hA5, 1'b0, 1'b0, 1'b0);
      check1("t1_busy_before_last", busy_a, 1'b1);
      check1("t1_valid_before_last", valid_a, 1'b0);
      idle_cycle();
      check1("t1_valid_after_last", valid_a, 1'b1);
      check8("t1_data_lsb", data_a, 8'hA5);
      check8("t1_data_msb", data_b, 8'hA5);
      check1("t1_busy_after", busy_a, 1'b0);
      repeat (2) idle_cycle();
      check1("t1_consumed", valid_a, 1'b0);

      // 2: same bits with gaps on alternate cycles
      send_word(8'hA5, 1'b1, 1'b0);
      repeat (2) idle_cycle();

      // 3: held word, second completion overflows and is dropped
      set_ready(1'b0);
      ovf0 = ovf_cnt_a;
      send_word(8'h3C, 1'b0, 1'b0);
      idle_cycle();
      check1("t3_held_valid", valid_a, 1'b1);
      send_word(8'hFF, 1'b0, 1'b1);
      repeat (3) idle_cycle();
      check_int("t3_overflow_pulses_lsb", ovf_cnt_a - ovf0, 1);
      check_int("t3_overflow_pulses_msb", ovf_cnt_b - ovf0, 1);
      check8("t3_data_kept_lsb", data_a, 8'h3C);
      check8("t3_data_kept_msb", data_b, 8'h3C);
      set_ready(1'b1);
      repeat (2) idle_cycle();
      check1("t3_drained", valid_a, 1'b0);

      // 4: three bits, then a restart aborts the partial word
      ferr0 = ferr_cnt_a;
      drive_bit(1'b1, 1'b1);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      send_word(8'h6B, 1'b0, 1'b0);
      repeat (2) idle_cycle();
      check_int("t4_frame_err_lsb", ferr_cnt_a - ferr0, 1);
      check_int("t4_frame_err_msb", ferr_cnt_b - ferr0, 1);
      check1("t4_busy_after", busy_a, 1'b0);

      // 5: word 2 completes on the cycle word 1 is consumed
      set_ready(1'b0);
      ovf0 = ovf_cnt_a;
      send_word(8'h12, 1'b0, 1'b0);
      send_bits(8'h5E, 1'b0, 1'b0, 1'b1);
      idle_cycle();
      check1("t5_valid_no_bubble", valid_a, 1'b1);
      check8("t5_data2_lsb", data_a, 8'h5E);
      check8("t5_data2_msb", data_b, 8'h7A);
      check_int("t5_no_overflow", ovf_cnt_a - ovf0, 0);
      repeat (2) idle_cycle();
      check1("t5_drained", valid_a, 1'b0);

      // 6: reset mid-word with a held output, then bits without start are ignored
      set_ready(1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b1);
      drive_bit(1'b1, 1'b0);
      reset_n = 1'b0;
      exp_a.delete();
      exp_b.delete();
      #1;
      check8("t6_rst_data_lsb", data_a, 8'h00);
      check8("t6_rst_data_msb", data_b, 8'h00);
      check1("t6_rst_valid", valid_a, 1'b0);
      check1("t6_rst_busy", busy_a, 1'b0);
      bit_valid = 1'b0;
      @(posedge clk); #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0);
      idle_cycle();
      idle_cycle();
      check1("t6_nostart_valid", valid_a, 1'b0);
      check1("t6_nostart_busy", busy_a, 1'b0);
      send_word(8'h9D, 1'b0, 1'b0);

      // drain with a bounded wait
      for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) idle_cycle();
      check_int("final_queue_lsb", exp_a.size(), 0);
      check_int("final_queue_msb", exp_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_sipo_deserializer
